// File: rtl/red_pitaya_fads_pkg.sv
// red_pitaya_fads_pkg: register map, FSM encoding and reset defaults shared by the FADS sort pulser.
package red_pitaya_fads_pkg;
    localparam logic [19:0] REG_DELAY    = 20'h00;
    localparam logic [19:0] REG_WIDTH    = 20'h04;
    localparam logic [19:0] REG_HOLDOFF  = 20'h08;
    localparam logic [19:0] REG_CTRL     = 20'h0C;
    localparam logic [19:0] REG_STATUS   = 20'h10;
    localparam logic [19:0] REG_SORT_CNT = 20'h14;
    localparam logic [19:0] REG_MISS_CNT = 20'h18;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int WIDTH_RST = 125;
endpackage

// File: rtl/sort_pulser_fsm.sv
// sort_pulser_fsm: trigger edge detect, delay/pulse/hold-off sequencer with shadowed timing.
module sort_pulser_fsm
    import red_pitaya_fads_pkg::*;
#(
    parameter int CW = 24
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          enable,
    input  logic          sort_trig_i,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] holdoff,
    output logic          sort_pulse,
    output logic          accept,
    output logic          miss,
    output logic          trig_q,
    output logic [1:0]    state
);
    logic [1:0]    state_n;
    logic [CW-1:0] cnt, cnt_n, sh_w, sh_h;
    logic          trig_edge;

    function automatic logic [CW-1:0] wm1(input logic [CW-1:0] w);
        return (w == '0) ? '0 : w - 1'b1;
    endfunction

    assign trig_edge = sort_trig_i & ~trig_q;
    assign accept    = trig_edge & enable & (state == ST_IDLE);
    assign miss      = trig_edge & enable & (state != ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt - 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_n = cnt;
                if (accept) begin
                    state_n = (delay == '0) ? ST_PULSE : ST_DELAY;
                    cnt_n   = (delay == '0) ? wm1(width) : delay - 1'b1;
                end
            end
            ST_DELAY: if (cnt == '0) begin
                state_n = ST_PULSE;
                cnt_n   = wm1(sh_w);
            end
            ST_PULSE: if (cnt == '0) begin
                state_n = (sh_h == '0) ? ST_IDLE : ST_HOLD;
                cnt_n   = sh_h - 1'b1;
            end
            ST_HOLD: if (cnt == '0) state_n = ST_IDLE;
        endcase
        // disable wins over everything, aborting any pulse in flight
        if (!enable) state_n = ST_IDLE;
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sh_w       <= '0;
            sh_h       <= '0;
            trig_q     <= 1'b0;
            sort_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            trig_q     <= sort_trig_i;
            sort_pulse <= (state_n == ST_PULSE);
            if (accept) begin
                sh_w <= width;
                sh_h <= holdoff;
            end
        end
    end
endmodule

// File: rtl/red_pitaya_sort_pulser.sv
// red_pitaya_sort_pulser: bus-configured delayed sort gate with accepted/missed event counters.
module red_pitaya_sort_pulser
    import red_pitaya_fads_pkg::*;
#(
    parameter int CW = 24,
    parameter int SW = 32
) (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    input  logic        sort_trig_i,
    output logic        sort_pulse_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);
    logic [CW-1:0] delay_r, width_r, holdoff_r;
    logic [SW-1:0] sort_cnt, miss_cnt;
    logic [31:0]   rdata_n;
    logic [1:0]    state;
    logic          enable, clr_q, accept, miss, trig_q, unused;

    assign unused  = ^{sys_sel, sys_addr[31:20], sys_wdata};
    assign sys_err = 1'b0;
    assign busy_o  = (state != ST_IDLE);

    sort_pulser_fsm #(.CW(CW)) u_fsm (
        .adc_clk_i   (adc_clk_i),
        .adc_rstn_i  (adc_rstn_i),
        .enable      (enable),
        .sort_trig_i (sort_trig_i),
        .delay       (delay_r),
        .width       (width_r),
        .holdoff     (holdoff_r),
        .sort_pulse  (sort_pulse_o),
        .accept      (accept),
        .miss        (miss),
        .trig_q      (trig_q),
        .state       (state)
    );

    always_comb begin
        rdata_n = '0;
        case (sys_addr[19:0])
            REG_DELAY:    rdata_n = 32'(delay_r);
            REG_WIDTH:    rdata_n = 32'(width_r);
            REG_HOLDOFF:  rdata_n = 32'(holdoff_r);
            REG_CTRL:     rdata_n = {31'd0, enable};
            REG_STATUS:   rdata_n = {29'd0, trig_q, state};
            REG_SORT_CNT: rdata_n = 32'(sort_cnt);
            REG_MISS_CNT: rdata_n = 32'(miss_cnt);
            default:      rdata_n = '0;
        endcase
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            delay_r   <= '0;
            width_r   <= CW'(WIDTH_RST);
            holdoff_r <= '0;
            enable    <= 1'b0;
            clr_q     <= 1'b0;
            sort_cnt  <= '0;
            miss_cnt  <= '0;
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack  <= sys_wen | sys_ren;
            clr_q    <= sys_wen && (sys_addr[19:0] == REG_CTRL) && sys_wdata[CTRL_CLR];
            // a pending clear beats a same-cycle increment
            sort_cnt <= clr_q ? '0 : sort_cnt + SW'(accept & ~&sort_cnt);
            miss_cnt <= clr_q ? '0 : miss_cnt + SW'(miss & ~&miss_cnt);
            if (sys_ren) sys_rdata <= rdata_n;
            if (sys_wen) begin
                case (sys_addr[19:0])
                    REG_DELAY:   delay_r   <= sys_wdata[CW-1:0];
                    REG_WIDTH:   width_r   <= sys_wdata[CW-1:0];
                    REG_HOLDOFF: holdoff_r <= sys_wdata[CW-1:0];
                    REG_CTRL:    enable    <= sys_wdata[CTRL_EN];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// tb_red_pitaya_sort_pulser: directed self-checking bench for the sort pulser.
module tb_red_pitaya_sort_pulser;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sort_trig = 1'b0;
    logic        sort_pulse, busy;
    logic [31:0] sys_addr = '0;
    logic [31:0] sys_wdata = '0;
    logic [3:0]  sys_sel = 4'hF;
    logic        sys_wen = 1'b0;
    logic        sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err, sys_ack;
    int          checks = 0;
    int          errors = 0;
    int          first, len, blen;
    logic [31:0] rd;

    always #4 clk = ~clk;

    red_pitaya_sort_pulser dut (
        .adc_clk_i    (clk),
        .adc_rstn_i   (rstn),
        .sort_trig_i  (sort_trig),
        .sort_pulse_o (sort_pulse),
        .busy_o       (busy),
        .sys_addr     (sys_addr),
        .sys_wdata    (sys_wdata),
        .sys_sel      (sys_sel),
        .sys_wen      (sys_wen),
        .sys_ren      (sys_ren),
        .sys_rdata    (sys_rdata),
        .sys_err      (sys_err),
        .sys_ack      (sys_ack)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(posedge clk); #1;
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        sys_addr = a; sys_ren = 1'b1;
        @(posedge clk); #1;
        sys_ren = 1'b0;
        check("read_ack", {31'd0, sys_ack}, 32'd1);
        d = sys_rdata;
    endtask

    // rising trigger sampled at the first edge of the loop (i=0), plus optional rises at offsets e2/e3
    task automatic measure(input int n, input int e2, input int e3, output int f, output int l, output int b);
        f = -1; l = 0; b = 0;
        sort_trig = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (sort_pulse && f < 0) f = i;
            l += int'(sort_pulse);
            b += int'(busy);
            sort_trig = (i + 1 == e2) || (i + 1 == e3);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse", {31'd0, sort_pulse}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, sys_ack}, 32'd0);
        check("rst_err", {31'd0, sys_err}, 32'd0);
        check("rst_rdata", sys_rdata, 32'd0);
        rstn = 1'b1;
        bus_read(32'h04, rd); check("rst_width", rd, 32'd125);
        bus_read(32'h14, rd); check("rst_sort_cnt", rd, 32'd0);

        bus_write(32'h00, 10); bus_write(32'h04, 5); bus_write(32'h08, 0); bus_write(32'h0C, 1);
        measure(30, -1, -1, first, len, blen);
        check("basic_rise", first, 10);
        check("basic_len", len, 5);
        check("basic_busy", blen, 15);
        bus_read(32'h14, rd); check("basic_sort_cnt", rd, 32'd1);

        bus_write(32'h00, 0); bus_write(32'h04, 0);
        measure(10, -1, -1, first, len, blen);
        check("zero_rise", first, 0);
        check("zero_len", len, 1);
        check("zero_busy", blen, 1);
        bus_read(32'h14, rd); check("zero_sort_cnt", rd, 32'd2);

        bus_write(32'h0C, 3);
        bus_read(32'h14, rd); check("clr_sort_cnt", rd, 32'd0);
        bus_read(32'h0C, rd); check("ctrl_clr_reads0", rd, 32'd1);

        bus_write(32'h04, 4); bus_write(32'h08, 20);
        measure(60, 10, 30, first, len, blen);
        check("miss_rise", first, 0);
        check("miss_len", len, 8);
        check("miss_busy", blen, 48);
        bus_read(32'h18, rd); check("miss_cnt", rd, 32'd1);
        bus_read(32'h14, rd); check("miss_sort_cnt", rd, 32'd2);

        bus_write(32'h00, 2); bus_write(32'h04, 10); bus_write(32'h08, 0);
        sort_trig = 1'b1;
        @(posedge clk); #1;
        sort_trig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_pulse_on", {31'd0, sort_pulse}, 32'd1);
        bus_write(32'h0C, 0);
        check("abort_pulse_held", {31'd0, sort_pulse}, 32'd1);
        @(posedge clk); #1;
        check("abort_pulse_off", {31'd0, sort_pulse}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        bus_read(32'h10, rd); check("abort_status", rd, 32'd0);
        measure(10, 5, -1, first, len, blen);
        check("dis_len", len, 0);
        check("dis_busy", blen, 0);
        bus_read(32'h14, rd); check("dis_sort_cnt", rd, 32'd3);
        bus_read(32'h18, rd); check("dis_miss_cnt", rd, 32'd1);

        bus_write(32'h0C, 1); bus_write(32'h00, 20); bus_write(32'h04, 5);
        sort_trig = 1'b1;
        @(posedge clk); #1;
        sort_trig = 1'b0;
        bus_write(32'h04, 50);
        len = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            len += int'(sort_pulse);
        end
        check("shadow_old_len", len, 5);
        measure(80, -1, -1, first, len, blen);
        check("shadow_new_rise", first, 20);
        check("shadow_new_len", len, 50);
        bus_read(32'h14, rd); check("shadow_sort_cnt", rd, 32'd5);

        @(posedge clk); #1;
        sys_addr = 32'h0C; sys_wdata = 3; sys_wen = 1'b1;
        @(posedge clk); #1;
        sys_wen = 1'b0; sort_trig = 1'b1;
        @(posedge clk); #1;
        sort_trig = 1'b0;
        check("coincide_busy", {31'd0, busy}, 32'd1);
        bus_read(32'h14, rd); check("coincide_sort_cnt", rd, 32'd0);

        bus_read(32'h04, rd); check("rd_width", rd, 32'd50);
        bus_read(32'h20, rd); check("rd_unmapped", rd, 32'd0);
        @(posedge clk); #1;
        check("ack_drop", {31'd0, sys_ack}, 32'd0);

        repeat (80) @(posedge clk);
        #1;
        bus_write(32'h00, 0);
        sort_trig = 1'b1;
        @(posedge clk); #1;
        sort_trig = 1'b0;
        check("rstmid_pulse_on", {31'd0, sort_pulse}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rstmid_pulse_off", {31'd0, sort_pulse}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        #2 rstn = 1'b1;
        bus_read(32'h04, rd); check("rstmid_width", rd, 32'd125);
        bus_read(32'h0C, rd); check("rstmid_ctrl", rd, 32'd0);
        bus_read(32'h14, rd); check("rstmid_sort_cnt", rd, 32'd0);
        bus_read(32'h10, rd); check("rstmid_status", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
